// File: rtl/spi_cmd_decoder_pkg.sv
// ---------------------------------------------------------------------------
// spiPkg
// Shared types and constants for the SPI command decoder.
//   spiCmdState_t  : decoder FSM states (idle, command byte, write, read)
//   SPI_CMD_WR_BIT : bit of the command byte that selects write (1) or read (0)
//   spiByte_t      : one SPI byte
// ---------------------------------------------------------------------------
package spiPkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } spiCmdState_t;

    localparam int SPI_CMD_WR_BIT = 7;

    typedef logic [7:0] spiByte_t;

endpackage

// File: rtl/spi_cmd_decoder.sv
// ---------------------------------------------------------------------------
// spi_cmd_decoder
// Frames SPI bytes into register-file commands. The first byte of a frame is
// the command (bit 7: 1 = write, 0 = read; low AW bits = start address).
// Write frames turn every following byte into a register write; read frames
// prefetch the addressed register and load it into the SPI transmit path.
// The address auto-increments modulo 2^AW.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous reset, active low
//   ssel       in   frame active (synchronised to clk)
//   rxValid    in   one-cycle strobe: new received byte on rxData
//   rxData     in   received byte
//   regWr      out  one-cycle register write strobe
//   regRd      out  one-cycle register read strobe
//   regAddr    out  register address for regWr/regRd
//   regWrData  out  write data, valid with regWr
//   regRdData  in   read data, valid one cycle after regRd
//   txData     out  byte for the next SPI transfer (held between loads)
//   txLoad     out  one-cycle strobe: txData updated
//   frameCnt   out  completed-frame counter, wraps at 16 bits
// ---------------------------------------------------------------------------
module spi_cmd_decoder
    import spiPkg::*;
#(
    parameter int AW = 7,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ssel,
    input  logic          rxValid,
    input  logic [DW-1:0] rxData,
    output logic          regWr,
    output logic          regRd,
    output logic [AW-1:0] regAddr,
    output logic [DW-1:0] regWrData,
    input  logic [DW-1:0] regRdData,
    output logic [DW-1:0] txData,
    output logic          txLoad,
    output logic [15:0]   frameCnt
);

    spiCmdState_t  state;
    spiCmdState_t  state_nxt;
    logic          ssel_q;
    logic [AW-1:0] addrCnt;
    logic [AW-1:0] addr_nxt;
    logic [AW-1:0] addr_inc;
    logic [AW-1:0] reg_addr_nxt;
    spiByte_t      wr_data_nxt;
    logic          wr_nxt;
    logic          rd_nxt;
    logic          frame_done;
    logic          rd_pend;

    assign addr_inc = addrCnt + AW'(1);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking assignments so every register
    // samples the pre-edge value of every other register, independent of
    // statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and next-output logic
    // ---------------------------------------------------------------------
    // NOTE: every variable gets a default before the case statement so no
    // path leaves one unassigned, which would infer a latch.
    always_comb begin
        state_nxt    = state;
        addr_nxt     = addrCnt;
        reg_addr_nxt = regAddr;
        wr_data_nxt  = regWrData;
        wr_nxt       = 1'b0;
        rd_nxt       = 1'b0;
        frame_done   = 1'b0;

        case (state)
            ST_IDLE: begin
                // Rising edge rather than level, so a reset released in the
                // middle of a frame does not misread a data byte as a command.
                if (ssel && !ssel_q) begin
                    state_nxt = ST_CMD;
                end
            end

            ST_CMD: begin
                if (rxValid) begin
                    addr_nxt = rxData[AW-1:0];
                    if (rxData[SPI_CMD_WR_BIT]) begin
                        state_nxt = ST_WRITE;
                    end else begin
                        // Prefetch the start address so it is ready to shift
                        // out during the master's first dummy byte.
                        state_nxt    = ST_READ;
                        rd_nxt       = 1'b1;
                        reg_addr_nxt = rxData[AW-1:0];
                    end
                end
                // A frame only counts once its command byte has arrived.
                if (!ssel) begin
                    state_nxt  = ST_IDLE;
                    frame_done = rxValid;
                end
            end

            ST_WRITE: begin
                if (rxValid) begin
                    wr_nxt       = 1'b1;
                    reg_addr_nxt = addrCnt;
                    wr_data_nxt  = rxData;
                    addr_nxt     = addr_inc;
                end
                if (!ssel) begin
                    state_nxt  = ST_IDLE;
                    frame_done = 1'b1;
                end
            end

            ST_READ: begin
                if (rxValid) begin
                    rd_nxt       = 1'b1;
                    reg_addr_nxt = addr_inc;
                    addr_nxt     = addr_inc;
                end
                if (!ssel) begin
                    state_nxt  = ST_IDLE;
                    frame_done = 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath registers and read pipeline
    // ---------------------------------------------------------------------
    // Read pipeline: regRd (n+1) -> rd_pend while regRdData is valid (n+2)
    // -> txData/txLoad (n+3). It completes even if the frame ends meanwhile.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // Treat ssel as already high so the first frame after reset needs
            // a genuine rising edge.
            ssel_q    <= 1'b1;
            addrCnt   <= '0;
            regWr     <= 1'b0;
            regRd     <= 1'b0;
            regAddr   <= '0;
            regWrData <= '0;
            rd_pend   <= 1'b0;
            txLoad    <= 1'b0;
            txData    <= '0;
            frameCnt  <= '0;
        end else begin
            ssel_q    <= ssel;
            addrCnt   <= addr_nxt;
            regWr     <= wr_nxt;
            regRd     <= rd_nxt;
            regAddr   <= reg_addr_nxt;
            regWrData <= wr_data_nxt;
            rd_pend   <= regRd;
            txLoad    <= rd_pend;
            if (rd_pend) begin
                txData <= regRdData;
            end
            if (frame_done) begin
                frameCnt <= frameCnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_spi_cmd_decoder
// Directed and randomised frames against spi_cmd_decoder. A peripheral model
// answers reads one cycle after regRd; expected strobes, addresses, data and
// cycle offsets are derived from the frame bytes alone.
// ---------------------------------------------------------------------------
module tb_spi_cmd_decoder;

    typedef struct {
        int         cyc;
        logic [6:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       reset;
    logic       ssel;
    logic       rxValid;
    logic [7:0] rxData;
    logic       regWr;
    logic       regRd;
    logic [6:0] regAddr;
    logic [7:0] regWrData;
    logic [7:0] regRdData;
    logic [7:0] txData;
    logic       txLoad;
    logic [15:0] frameCnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int both_cnt = 0;
    int exp_frames = 0;
    logic init_mem = 1'b1;

    logic [7:0] mem     [128];
    logic [7:0] ref_regs[128];
    logic [7:0] frame_bytes[$];
    int         rx_cyc[$];
    ev_t        wr_log[$];
    ev_t        rd_log[$];
    ev_t        tx_log[$];
    int         wr_base, rd_base, tx_base;

    spi_cmd_decoder #(.AW(7), .DW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .ssel      (ssel),
        .rxValid   (rxValid),
        .rxData    (rxData),
        .regWr     (regWr),
        .regRd     (regRd),
        .regAddr   (regAddr),
        .regWrData (regWrData),
        .regRdData (regRdData),
        .txData    (txData),
        .txLoad    (txLoad),
        .frameCnt  (frameCnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register-file peripheral: read data valid one cycle after regRd.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int k = 0; k < 128; k++) mem[k] <= 8'(k) ^ 8'hA5;
        end else if (regWr) begin
            mem[regAddr] <= regWrData;
        end
        if (regRd) regRdData <= mem[regAddr];
    end

    // Event monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (regWr)  wr_log.push_back(ev_t'{cyc, regAddr, regWrData});
        if (regRd)  rd_log.push_back(ev_t'{cyc, regAddr, 8'h00});
        if (txLoad) tx_log.push_back(ev_t'{cyc, 7'h00, txData});
        if (regWr && regRd) both_cnt <= both_cnt + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, cycle %0d expected < 100000", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic mark_logs();
        wr_base = wr_log.size();
        rd_base = rd_log.size();
        tx_base = tx_log.size();
        rx_cyc.delete();
    endtask

    task automatic start_frame();
        @(posedge clk); #1;
        ssel = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit drop_ssel);
        @(posedge clk); #1;
        rxValid = 1'b1;
        rxData  = b;
        if (drop_ssel) ssel = 1'b0;
        rx_cyc.push_back(cyc);
        @(posedge clk); #1;
        rxValid = 1'b0;
        rxData  = $urandom_range(0, 255);
        repeat (8) @(posedge clk);
    endtask

    task automatic end_frame();
        @(posedge clk); #1;
        ssel = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    // Expected behaviour from the frame bytes: writes to start+i-1 for data
    // byte i, or reads of start+i for every byte i (command included) with
    // the value loaded for transmit three cycles after each byte.
    task automatic check_frame(input string name);
        ev_t exp_wr[$];
        ev_t exp_rd[$];
        ev_t exp_tx[$];
        int  n = frame_bytes.size();
        int  start, a, m;
        if (n > 0) begin
            start = int'(frame_bytes[0]) % 128;
            if (frame_bytes[0] >= 8'h80) begin
                for (int i = 1; i < n; i++) begin
                    a = (start + i - 1) % 128;
                    exp_wr.push_back(ev_t'{rx_cyc[i] + 1, 7'(a), frame_bytes[i]});
                    ref_regs[a] = frame_bytes[i];
                end
            end else begin
                for (int i = 0; i < n; i++) begin
                    a = (start + i) % 128;
                    exp_rd.push_back(ev_t'{rx_cyc[i] + 1, 7'(a), 8'h00});
                    exp_tx.push_back(ev_t'{rx_cyc[i] + 3, 7'h00, ref_regs[a]});
                end
            end
            exp_frames++;
        end

        check({name, " wr count"}, wr_log.size() - wr_base, exp_wr.size());
        m = (wr_log.size() - wr_base < exp_wr.size()) ? wr_log.size() - wr_base : exp_wr.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s wr%0d addr", name, i), wr_log[wr_base+i].addr, exp_wr[i].addr);
            check($sformatf("%s wr%0d data", name, i), wr_log[wr_base+i].data, exp_wr[i].data);
            check($sformatf("%s wr%0d cycle", name, i), wr_log[wr_base+i].cyc, exp_wr[i].cyc);
        end
        check({name, " rd count"}, rd_log.size() - rd_base, exp_rd.size());
        m = (rd_log.size() - rd_base < exp_rd.size()) ? rd_log.size() - rd_base : exp_rd.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s rd%0d addr", name, i), rd_log[rd_base+i].addr, exp_rd[i].addr);
            check($sformatf("%s rd%0d cycle", name, i), rd_log[rd_base+i].cyc, exp_rd[i].cyc);
        end
        check({name, " tx count"}, tx_log.size() - tx_base, exp_tx.size());
        m = (tx_log.size() - tx_base < exp_tx.size()) ? tx_log.size() - tx_base : exp_tx.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s tx%0d data", name, i), tx_log[tx_base+i].data, exp_tx[i].data);
            check($sformatf("%s tx%0d cycle", name, i), tx_log[tx_base+i].cyc, exp_tx[i].cyc);
        end
        check({name, " frameCnt"}, frameCnt, 16'(exp_frames));
        check({name, " wr/rd overlap"}, both_cnt, 0);
    endtask

    task automatic run_frame(input string name, input bit drop_on_last);
        mark_logs();
        start_frame();
        for (int i = 0; i < frame_bytes.size(); i++) begin
            send_byte(frame_bytes[i], drop_on_last && (i == frame_bytes.size() - 1));
        end
        end_frame();
        check_frame(name);
    endtask

    initial begin
        int nb;
        bit drop;
        for (int k = 0; k < 128; k++) ref_regs[k] = 8'(k) ^ 8'hA5;
        reset   = 1'b0;
        ssel    = 1'b0;
        rxValid = 1'b0;
        rxData  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        init_mem = 1'b0;
        check("reset regWr", regWr, 0);
        check("reset regRd", regRd, 0);
        check("reset txLoad", txLoad, 0);
        check("reset txData", txData, 8'h00);
        check("reset frameCnt", frameCnt, 16'h0);
        reset = 1'b1;
        repeat (3) @(posedge clk);

        frame_bytes = '{8'h85, 8'h11, 8'h22};
        run_frame("write", 1'b0);

        frame_bytes = '{8'h10, 8'h00, 8'h00};
        run_frame("read", 1'b0);

        frame_bytes = '{8'hFF, 8'hC3, 8'h3C};
        run_frame("wrap", 1'b0);

        frame_bytes = '{8'h83, 8'h44, 8'h55};
        run_frame("coincident", 1'b1);

        // Byte outside a frame: no strobes, counter unchanged.
        mark_logs();
        send_byte(8'h82, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        frame_bytes.delete();
        check_frame("stray byte");

        // ssel pulse without any byte.
        frame_bytes.delete();
        run_frame("empty frame", 1'b0);

        // Asynchronous reset in the middle of a write frame.
        mark_logs();
        start_frame();
        send_byte(8'h90, 1'b0);
        send_byte(8'h77, 1'b0);
        ref_regs[8'h10] = 8'h77;
        check("pre-reset write", wr_log.size() - wr_base, 1);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("async reset regWr", regWr, 0);
        check("async reset regRd", regRd, 0);
        check("async reset txLoad", txLoad, 0);
        check("async reset regAddr", regAddr, 7'h00);
        check("async reset regWrData", regWrData, 8'h00);
        check("async reset txData", txData, 8'h00);
        check("async reset frameCnt", frameCnt, 16'h0);
        exp_frames = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        wr_base = wr_log.size();
        send_byte(8'h33, 1'b0);
        end_frame();
        check("resync ignores mid-frame byte", wr_log.size() - wr_base, 0);
        check("resync frameCnt", frameCnt, 16'h0);
        frame_bytes = '{8'h81, 8'h5A};
        run_frame("after reset", 1'b0);

        // Randomised frames.
        for (int f = 0; f < 24; f++) begin
            frame_bytes.delete();
            nb = $urandom_range(0, 5);
            for (int i = 0; i < nb; i++) frame_bytes.push_back(8'($urandom_range(0, 255)));
            drop = ($urandom_range(0, 3) == 0) && (nb > 0);
            run_frame($sformatf("rand%0d", f), drop);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_cmd_decoder.md
# spi_cmd_decoder

Byte-level command decoder sitting directly downstream of the SPI slave checker stage. It consumes the received-byte strobe and data, frames commands using the slave-select level, and turns them into register-file read/write strobes with address auto-increment. For reads it loads the addressed register value back into the SPI slave transmit path.

## Interface
Parameters:
- `AW`, default 7: register address width; command byte carries `AW` ≤ 7 address bits.
- `DW`, default 8: data width; fixed at 8, one SPI byte per register.

Ports:
- `clk` in 1: system clock, 50 MHz on DE1-SoC.
- `reset` in 1: asynchronous, active-low reset.
- `ssel` in 1: frame active, active-high, already synchronised to `clk`.
- `rxValid` in 1: one-cycle strobe, new byte received (the upstream `spiEnd`).
- `rxData` in 8: received byte, valid while `rxValid`=1.
- `regWr` out 1: one-cycle register write strobe.
- `regRd` out 1: one-cycle register read strobe.
- `regAddr` out AW: register address for `regWr`/`regRd`.
- `regWrData` out 8: write data, valid with `regWr`.
- `regRdData` in 8: read data, valid exactly 1 cycle after `regRd`.
- `txData` out 8: byte to shift out on the next SPI byte.
- `txLoad` out 1: one-cycle strobe, `txData` updated.
- `frameCnt` out 16: completed frames, wraps at 0xFFFF→0.

## Operation
- Command byte is the first byte of a frame:
  - Bit7=1 selects write; bit7=0 selects read.
  - Bits[AW-1:0] are the start address. Unused bits are ignored.
- FSM states: IDLE, CMD, WRITE, READ.
- IDLE: waits for `ssel`=1, then goes to CMD. `rxValid` while `ssel`=0 is ignored.
- CMD: on `rxValid`, latch the address into `addrCnt`.
  - Write command → WRITE.
  - Read command → READ, and issue a read of `addrCnt` (prefetch for the next SPI byte).
- WRITE: each `rxValid` issues `regWr` with `regAddr`=`addrCnt`, `regWrData`=`rxData`, then increments `addrCnt`.
- READ: each `rxValid` (dummy byte from master) increments `addrCnt` and issues a read of the new address, which is loaded to `txData`.
- Address arithmetic is modulo 2^AW (wrap-around, 127→0 for AW=7).
- `ssel` falling in any non-IDLE state → IDLE and `frameCnt` increments.
  - Exception: a frame ending in CMD without a command byte does not count.
- `ssel`=0 and `rxValid`=1 in the same cycle: the byte is fully processed (write issued), then IDLE.
- `txData` is not cleared at frame end; it holds the last loaded value.
- Reset values: FSM=IDLE, `regWr`=`regRd`=`txLoad`=0, `regAddr`=0, `regWrData`=0, `txData`=0x00, `frameCnt`=0, `addrCnt`=0.
- Reset mid-frame: immediate return to IDLE. The frame in progress is discarded; the decoder re-syncs on the next `ssel` rising edge.

## Timing
- `rxValid` at cycle n → `regWr`/`regRd` registered at n+1.
- Read path: `regRd` at n+1, `regRdData` sampled at n+2, `txData`/`txLoad` at n+3.
- Upstream guarantee: at least 8 `clk` cycles between consecutive `rxValid` pulses, so no backpressure exists. A pulse arriving earlier is still processed; no queueing is required.
- `regWr` and `regRd` are never high in the same cycle.
- `frameCnt` updates 1 cycle after the `ssel` falling edge is observed.

## Structure
- Package `spiPkg`:
  - FSM state enum `spiCmdState_t`.
  - Constant `SPI_CMD_WR_BIT`=7.
  - Byte type `spiByte_t`.
- Single module, no sub-modules. The read pipeline (pending flag plus `txLoad` stage) is a small inline two-stage shift.
- Instantiated in the DE1-SoC wrapper:
  - `rxValid`/`rxData` come from the checker's `spiEnd`/`spiRxData`.
  - `txData`/`txLoad` feed the slave's MISO loader.

## Test plan
- Write frame: `ssel`=1, bytes 0x85,0x11,0x22 → `regWr` to addr 0x05 data 0x11, then addr 0x06 data 0x22; `frameCnt`=1 after `ssel`=0.
- Read frame with a bench register model (reg[k]=k^0xA5): bytes 0x10,0x00,0x00 →
  - `regRd` at 0x10, 0x11, 0x12.
  - `txData` sequence 0xB5, 0xB4, 0xB7, each with `txLoad` 3 cycles after the triggering `rxValid`.
- Wrap: write cmd 0xFF, then 2 data bytes → writes at addr 0x7F then 0x00.
- Edge cases:
  - Byte with `ssel`=0 → ignored, no strobes.
  - Frame with `ssel` pulse but no byte → `frameCnt` unchanged.
  - Last `rxValid` coincident with `ssel` fall → write still issued.
- Reset: assert `reset`=0 mid-WRITE frame → all outputs at reset values asynchronously. The next frame, started with 0x81,0x5A, writes addr 0x01 data 0x5A.
